multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Control FSM for the lab multi-cycle CPU datapath.
- Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives the datapath write strobes, mux selects and ALU op, and runs a request/ready handshake with unified memory.
- Handles start/halt, a global enable (step/freeze), a memory timeout fault, and a retired-instruction counter.

Parameters:
- OPCODE_W, 4, opcode width taken from IR[15:12]
- MEM_TIMEOUT, 16, max cycles to wait for mem_ready before faulting (>=1)
- RETIRED_W, 16, retired-instruction counter width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  pulse; IDLE->FETCH, HALT->FETCH; ignored elsewhere
- enable  in  1  0 freezes FSM/counters and forces all strobes to 0
- opcode  in  OPCODE_W  current IR opcode, valid from DECODE onward
- zero  in  1  ALU zero flag, sampled in EXEC
- mem_ready  in  1  memory completes access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write (valid with mem_req)
- addr_sel  out  1  0 = PC, 1 = ALU result
- ir_write  out  1  load IR from memory data
- pc_write  out  1  load PC
- pc_src  out  2  00 PC+1, 01 branch target, 10 jump target
- alu_src_b  out  1  0 = register, 1 = immediate
- alu_op  out  2  00 add, 01 sub, 10 and, 11 or
- reg_write  out  1  register file write
- wb_sel  out  1  0 = ALU result, 1 = memory data
- state  out  3  current FSM state encoding
- busy  out  1  state not IDLE and not HALT
- halted  out  1  state == HALT
- fault  out  1  sticky memory-timeout flag
- retired  out  RETIRED_W  retired-instruction count, wraps

Behaviour:
- Reset (synchronous):
  - state = IDLE, retired = 0, fault = 0, timeout counter = 0.
  - All control outputs are 0 while in IDLE.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Value 7 is unreachable and recovers to IDLE.
- Output timing: outputs are combinational from the registered state, opcode, zero and mem_ready. Every strobe (mem_req, mem_we, ir_write, pc_write, reg_write) is ANDed with enable.
- Opcodes: ADD=0, SUB=1, AND=2, OR=3, ADDI=4, LW=5, SW=6, BEQ=7, JMP=8, HALT=F. All other values are illegal and execute as NOP.
- FETCH:
  - Drives mem_req=1, addr_sel=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=00, then -> DECODE.
- DECODE:
  - JMP: pc_write=1, pc_src=10, retire, -> FETCH.
  - HALT: retire, -> HALT.
  - Illegal: retire, -> FETCH.
  - Everything else: -> EXEC.
- EXEC:
  - ALU ops: alu_op from opcode[1:0], alu_src_b=0; ADDI uses alu_op=00, alu_src_b=1. Then -> WB.
  - LW/SW: alu_op=00, alu_src_b=1, -> MEM.
  - BEQ: alu_op=01, alu_src_b=0; pc_write=zero, pc_src=01; retire, -> FETCH.
- MEM:
  - Drives mem_req=1, addr_sel=1, mem_we=(SW).
  - On mem_ready: LW -> WB; SW retires and -> FETCH.
- WB: reg_write=1, wb_sel=(LW); retire, -> FETCH.
- HALT: all strobes 0, halted=1. On start: fault cleared, -> FETCH.
- Retire: retired increments by 1 on the cycle the FSM leaves an instruction's final state; it wraps to 0 after all-ones.
- Latencies with zero-wait memory (mem_ready high in the first request cycle), counting from the FETCH entry cycle:
  - ALU / ADDI: 4 cycles. LW: 5. SW: 4. BEQ: 3. JMP: 2.
- Timeout:
  - The counter resets on every state change.
  - It increments each enabled cycle in which mem_req=1 and mem_ready=0.
  - When it reaches MEM_TIMEOUT: fault=1, -> HALT, no retire.
- enable=0:
  - state, retired and the timeout counter hold; mem_ready is ignored; strobes read 0.
  - Memory must tolerate mem_req dropping mid-wait; the request is reissued when enable returns.
- Simultaneous events:
  - reset beats everything.
  - start while busy is ignored.
  - mem_ready in the same cycle the timeout is reached: mem_ready wins.
  - reset mid-instruction: abandons it with no retire and returns to IDLE.

Decomposition:
- Shared package cpu_pkg holds:
  - state encodings (STATE_IDLE..STATE_HALT)
  - opcode constants (OP_ADD..OP_HALT)
  - alu_op and pc_src encodings
- These constants are shared with the datapath and the bench.
- One natural sub-module: seq_timeout_counter (counter, clear on state change, terminal-count flag).

Test Plan:
1. Reset, pulse start, ADD with zero-wait memory -> states 1,2,3,5,1; reg_write=1 for 1 cycle in WB; retired=1 after 4 cycles.
2. LW with mem_ready delayed 3 cycles in both FETCH and MEM -> mem_req held high throughout; 11 cycles total; wb_sel=1 and reg_write in WB; retired=1.
3. BEQ with zero=1, then BEQ with zero=0 -> pc_write=1 with pc_src=01 only in the first EXEC; both retire; retired=2.
4. MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> after 4 cycles state=6, fault=1, halted=1, retired unchanged; start -> fault=0, state=1.
5. enable=0 for 5 cycles mid-SW MEM -> state stays 4, mem_req=mem_we=0, counter frozen; enable=1 with mem_ready -> retire and state=1.
6. Preload retired=0xFFFF path via 65536 JMPs (or force), plus HALT opcode and illegal opcode 0xA -> retired wraps to 0; HALT -> state 6; 0xA -> NOP, retire, back to FETCH.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: state, opcode, alu_op and pc_src encodings shared by sequencer, datapath and bench
package cpu_pkg;
  localparam logic [2:0] STATE_IDLE   = 3'd0;
  localparam logic [2:0] STATE_FETCH  = 3'd1;
  localparam logic [2:0] STATE_DECODE = 3'd2;
  localparam logic [2:0] STATE_EXEC   = 3'd3;
  localparam logic [2:0] STATE_MEM    = 3'd4;
  localparam logic [2:0] STATE_WB     = 3'd5;
  localparam logic [2:0] STATE_HALT   = 3'd6;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;
  localparam logic [1:0] PC_PLUS1  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
endpackage

// File: rtl/seq_timeout_counter.sv
// seq_timeout_counter: memory wait counter, cleared on state change, flags the cycle it reaches MAX
module seq_timeout_counter #(
  parameter int MAX = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic done
);
  localparam int CW = $clog2(MAX + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clock)
    if (reset || clear) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  assign done = inc && cnt == CW'(MAX - 1);
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: control FSM sequencing FETCH/DECODE/EXEC/MEM/WB for the multi-cycle CPU
module multicycle_sequencer
  import cpu_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int RETIRED_W   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 enable,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 addr_sel,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 reg_write,
  output logic                 wb_sel,
  output logic [2:0]           state,
  output logic                 busy,
  output logic                 halted,
  output logic                 fault,
  output logic [RETIRED_W-1:0] retired
);
  logic [3:0] op;
  logic [2:0] nxt;
  logic retire, tmo, clear, inc;
  logic in_fetch, in_dec, in_exec, in_mem, in_wb;
  logic is_alu, is_addi, is_lw, is_sw, is_beq, is_jmp, is_hlt, is_ill;
  assign op       = 4'(opcode);
  assign is_alu   = op <= OP_OR;
  assign is_addi  = op == OP_ADDI;
  assign is_lw    = op == OP_LW;
  assign is_sw    = op == OP_SW;
  assign is_beq   = op == OP_BEQ;
  assign is_jmp   = op == OP_JMP;
  assign is_hlt   = op == OP_HALT;
  assign is_ill   = op > OP_JMP && !is_hlt;
  assign in_fetch = state == STATE_FETCH;
  assign in_dec   = state == STATE_DECODE;
  assign in_exec  = state == STATE_EXEC;
  assign in_mem   = state == STATE_MEM;
  assign in_wb    = state == STATE_WB;
  always_comb begin
    nxt = state;
    retire = 1'b0;
    case (state)
      STATE_IDLE:   nxt = start ? STATE_FETCH : STATE_IDLE;
      STATE_FETCH:  nxt = mem_ready ? STATE_DECODE : tmo ? STATE_HALT : STATE_FETCH;
      STATE_DECODE: begin
        nxt = (is_jmp || is_ill) ? STATE_FETCH : is_hlt ? STATE_HALT : STATE_EXEC;
        retire = is_jmp || is_ill || is_hlt;
      end
      STATE_EXEC: begin
        nxt = (is_lw || is_sw) ? STATE_MEM : is_beq ? STATE_FETCH : STATE_WB;
        retire = is_beq;
      end
      STATE_MEM: begin
        nxt = mem_ready ? (is_lw ? STATE_WB : STATE_FETCH) : tmo ? STATE_HALT : STATE_MEM;
        retire = mem_ready && is_sw;
      end
      STATE_WB: begin
        nxt = STATE_FETCH;
        retire = 1'b1;
      end
      STATE_HALT:   nxt = start ? STATE_FETCH : STATE_HALT;
      default:      nxt = STATE_IDLE;
    endcase
  end
  // the wait counter only advances while a request is actually outstanding on the bus
  assign inc   = enable && (in_fetch || in_mem) && !mem_ready;
  assign clear = enable && nxt != state;
  seq_timeout_counter #(.MAX(MEM_TIMEOUT)) u_tmo (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .inc   (inc),
    .done  (tmo)
  );
  always_ff @(posedge clock)
    if (reset) begin
      state   <= STATE_IDLE;
      retired <= '0;
      fault   <= 1'b0;
    end else if (enable) begin
      state   <= nxt;
      retired <= retired + RETIRED_W'(retire);
      fault   <= tmo ? 1'b1 : (state == STATE_HALT && start) ? 1'b0 : fault;
    end
  assign mem_req   = enable && (in_fetch || in_mem);
  assign mem_we    = enable && in_mem && is_sw;
  assign addr_sel  = in_mem;
  assign ir_write  = enable && in_fetch && mem_ready;
  assign pc_write  = enable && ((in_fetch && mem_ready) || (in_dec && is_jmp) || (in_exec && is_beq && zero));
  assign pc_src    = (in_dec && is_jmp) ? PC_JUMP : (in_exec && is_beq) ? PC_BRANCH : PC_PLUS1;
  assign alu_src_b = in_exec && (is_addi || is_lw || is_sw);
  assign alu_op    = !in_exec ? ALU_ADD : is_alu ? op[1:0] : is_beq ? ALU_SUB : ALU_ADD;
  assign reg_write = enable && in_wb;
  assign wb_sel    = in_wb && is_lw;
  assign busy      = state != STATE_IDLE && state != STATE_HALT;
  assign halted    = state == STATE_HALT;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: cycle-by-cycle control checks plus a retire-count scoreboard
module tb_multicycle_sequencer;
  import cpu_pkg::*;
  localparam int RW = 8;
  logic clock = 0, reset = 1, start = 0, enable = 1, zero = 0, mem_ready = 0;
  logic [3:0] opcode = 0;
  logic mem_req, mem_we, addr_sel, ir_write, pc_write, alu_src_b, reg_write, wb_sel, busy, halted, fault;
  logic [1:0] pc_src, alu_op;
  logic [2:0] state;
  logic [RW-1:0] retired, model = 0, last = 0;
  logic [RW-1:0] sb[$];
  logic exp_fault = 0, rs;
  int n_checks = 0, n_errors = 0;
  multicycle_sequencer #(.OPCODE_W(4), .MEM_TIMEOUT(4), .RETIRED_W(RW)) dut (
    .clock(clock), .reset(reset), .start(start), .enable(enable), .opcode(opcode),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel),
    .state(state), .busy(busy), .halted(halted), .fault(fault), .retired(retired)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // retire scoreboard: every change of retired must match the next expected count
  always @(posedge clock) begin
    rs = reset;
    #2;
    if (rs) last = retired;
    else if (retired !== last) begin
      if (sb.size() == 0) check("retire_unexpected", 32'(retired), 32'(last));
      else check("retire", 32'(retired), 32'(sb.pop_front()));
      last = retired;
    end
  end
  task automatic push_retire();
    model = model + 1'b1;
    sb.push_back(model);
  endtask
  // stb = {mem_req, mem_we, ir_write, pc_write, reg_write}; sel = {addr_sel, pc_src, alu_src_b, alu_op, wb_sel}
  task automatic tick(input string tag, input logic [2:0] es, input logic [4:0] stb, input logic [6:0] sel);
    @(negedge clock);
    check({tag, ".state"}, 32'(state), 32'(es));
    check({tag, ".stb"}, 32'({mem_req, mem_we, ir_write, pc_write, reg_write}), 32'(stb));
    check({tag, ".sel"}, 32'({addr_sel, pc_src, alu_src_b, alu_op, wb_sel}), 32'(sel));
    check({tag, ".sts"}, 32'({busy, halted, fault}),
          32'({es != STATE_IDLE && es != STATE_HALT, es == STATE_HALT, exp_fault}));
    @(posedge clock);
    #1;
  endtask
  task automatic instr(input logic [3:0] op, input logic z, input int fw, input int mw, input int fz);
    logic sw;
    sw = op == OP_SW;
    opcode = op;
    zero = z;
    mem_ready = 0;
    repeat (fw) tick("fetch_wait", STATE_FETCH, 5'b10000, 7'd0);
    mem_ready = 1;
    tick("fetch", STATE_FETCH, 5'b10110, 7'd0);
    mem_ready = 0;
    if (op == OP_JMP) begin
      push_retire();
      tick("dec_jmp", STATE_DECODE, 5'b00010, {1'b0, PC_JUMP, 4'b0});
      return;
    end
    if (op > OP_JMP) begin
      push_retire();
      tick("dec_end", STATE_DECODE, 5'b00000, 7'd0);
      return;
    end
    tick("dec", STATE_DECODE, 5'b00000, 7'd0);
    if (op == OP_BEQ) begin
      push_retire();
      tick("beq", STATE_EXEC, {3'b000, z, 1'b0}, {1'b0, PC_BRANCH, 1'b0, ALU_SUB, 1'b0});
      return;
    end
    tick("exec", STATE_EXEC, 5'b00000, {3'b000, op >= OP_ADDI, op <= OP_OR ? op[1:0] : ALU_ADD, 1'b0});
    if (op == OP_LW || sw) begin
      repeat (mw) tick("mem_wait", STATE_MEM, {1'b1, sw, 3'b000}, 7'b1000000);
      if (fz > 0) begin
        enable = 0;
        mem_ready = 1;
        repeat (fz) tick("mem_frozen", STATE_MEM, 5'b00000, 7'b1000000);
        enable = 1;
      end
      mem_ready = 1;
      if (sw) push_retire();
      tick("mem", STATE_MEM, {1'b1, sw, 3'b000}, 7'b1000000);
      mem_ready = 0;
      if (sw) return;
    end
    push_retire();
    tick("wb", STATE_WB, 5'b00001, {6'b0, op == OP_LW});
  endtask
  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    check("rst_retired", 32'(retired), 0);
    tick("idle", STATE_IDLE, 5'b00000, 7'd0);
    start = 1;
    tick("idle_start", STATE_IDLE, 5'b00000, 7'd0);
    start = 0;
    instr(OP_ADD, 0, 0, 0, 0);
    instr(OP_LW, 0, 3, 3, 0);
    instr(OP_BEQ, 1, 0, 0, 0);
    instr(OP_BEQ, 0, 0, 0, 0);
    check("retired_after_beq", 32'(retired), 4);
    instr(OP_SUB, 0, 1, 0, 0);
    instr(OP_AND, 0, 0, 0, 0);
    instr(OP_OR, 0, 0, 0, 0);
    instr(OP_ADDI, 0, 0, 0, 0);
    instr(OP_SW, 0, 2, 1, 0);
    instr(OP_SW, 0, 0, 3, 5);
    instr(OP_JMP, 0, 0, 0, 0);
    instr(4'hA, 0, 0, 0, 0);
    start = 1;
    instr(OP_ADD, 0, 0, 0, 0);
    start = 0;
    mem_ready = 0;
    repeat (4) tick("to_wait", STATE_FETCH, 5'b10000, 7'd0);
    exp_fault = 1;
    tick("to_halt", STATE_HALT, 5'b00000, 7'd0);
    start = 1;
    tick("to_restart", STATE_HALT, 5'b00000, 7'd0);
    start = 0;
    exp_fault = 0;
    instr(OP_HALT, 0, 0, 0, 0);
    tick("halt", STATE_HALT, 5'b00000, 7'd0);
    enable = 0;
    start = 1;
    tick("halt_frozen", STATE_HALT, 5'b00000, 7'd0);
    enable = 1;
    tick("halt_go", STATE_HALT, 5'b00000, 7'd0);
    start = 0;
    while (model != 0) instr(OP_JMP, 0, 0, 0, 0);
    check("wrap", 32'(retired), 0);
    instr(OP_ADD, 0, 0, 0, 0);
    opcode = OP_LW;
    mem_ready = 1;
    tick("rst_fetch", STATE_FETCH, 5'b10110, 7'd0);
    mem_ready = 0;
    tick("rst_dec", STATE_DECODE, 5'b00000, 7'd0);
    reset = 1;
    tick("rst_exec", STATE_EXEC, 5'b00000, {3'b000, 1'b1, ALU_ADD, 1'b0});
    reset = 0;
    model = 0;
    tick("rst_idle", STATE_IDLE, 5'b00000, 7'd0);
    check("rst_retired2", 32'(retired), 0);
    check("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
